// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FWFT FIFO with occupancy, thresholds, flush and high-water mark
// Pointers carry an extra wrap bit so all DEPTH entries are usable.
module stream_fifo #(
  parameter int DATAW     = 64,
  parameter int DEPTH     = 128,
  parameter int ADDRW     = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic [ADDRW:0]   count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDRW:0]   max_count
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two >= 2");
  end
  if (ADDRW != $clog2(DEPTH)) begin : g_bad_addrw
    $error("stream_fifo: ADDRW must equal clog2(DEPTH)");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("stream_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("stream_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  localparam logic [ADDRW:0] AF_T = (ADDRW + 1)'(AF_THRESH);
  localparam logic [ADDRW:0] AE_T = (ADDRW + 1)'(AE_THRESH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [ADDRW:0]   wptr;
  logic [ADDRW:0]   rptr;
  logic [ADDRW:0]   wptr_nx;
  logic [ADDRW:0]   rptr_nx;
  logic [ADDRW:0]   count_nx;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDRW-1:0] == rptr[ADDRW-1:0]) && (wptr[ADDRW] != rptr[ADDRW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rptr[ADDRW-1:0]];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wptr_nx  = wptr + {{ADDRW{1'b0}}, push};
  assign rptr_nx  = rptr + {{ADDRW{1'b0}}, pop};
  assign count    = wptr - rptr;
  assign count_nx = wptr_nx - rptr_nx;

  assign almost_full  = (count >= AF_T);
  assign almost_empty = (count <= AE_T);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      max_count <= '0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      max_count <= '0;
    end else begin
      wptr <= wptr_nx;
      rptr <= rptr_nx;
      if (count_nx > max_count) max_count <= count_nx;
    end
  end

  // Storage is never reset; a flushed push must not land either.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[ADDRW-1:0]] <= in_data;
  end

endmodule
